// File: rtl/core_pkg.sv
// Shared types and defaults for the data-memory stall sequencer.
// The bus timeout is compiled in only when DMEM_TIMEOUT_EN is defined.
package core_pkg;

   typedef enum logic [1:0] {
      MSEQ_IDLE = 2'd0,
      MSEQ_BUS  = 2'd1,
      MSEQ_DONE = 2'd2
   } mseq_state_t;

   // Default number of BUS cycles without ack before the access is abandoned.
   localparam int unsigned DMEM_TIMEOUT_CYCLES_DEFAULT = 255;

   // Counter width able to hold 0 .. n-1 (at least one bit).
   function automatic int unsigned tcount_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts BUS cycles without acknowledge. tc is high while the count sits on
// its last value (CYCLES-1), i.e. during the CYCLES-th unacknowledged cycle.
// Only instantiated when DMEM_TIMEOUT_EN is defined.
module bus_timeout_counter
   import core_pkg::*;
#(
   parameter int unsigned CYCLES = DMEM_TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int unsigned CW = tcount_width(CYCLES);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] count;

   assign tc = (count == LAST);

   // Count up while enabled; saturate at the terminal value.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dmem_stall_sequencer.sv
// Sequences MEM-stage loads/stores onto a single-outstanding wait-state data
// bus and generates the pipeline freeze request.
// Optional feature: define DMEM_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYCLES unacknowledged BUS cycles and report it on bus_err.
//
// Handshake: the MEM stage holds mem_req (and its fields) while stall_pipl is
// high; the bus side keeps cyc/stb high from the first BUS cycle until the
// cycle in which dbus_ack is sampled high, so exactly one transfer completes
// per request. mem_done marks every DONE cycle; the response (mem_rdata,
// bus_err) is stable for all of them.
module dmem_stall_sequencer
   import core_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W/8-1:0]   mem_sel,
   input  logic                  ext_stall,
   output logic                  stall_pipl,
   output logic [DATA_W-1:0]     mem_rdata,
   output logic                  mem_done,
   output logic                  bus_err,
   output logic                  dbus_cyc,
   output logic                  dbus_stb,
   output logic                  dbus_we,
   output logic [ADDR_W-1:0]     dbus_addr,
   output logic [DATA_W-1:0]     dbus_wdata,
   output logic [DATA_W/8-1:0]   dbus_sel,
   input  logic [DATA_W-1:0]     dbus_rdata,
   input  logic                  dbus_ack,
   output mseq_state_t           dbg_state
);

   mseq_state_t state;
   logic        timeout;

   // A zero timeout would end every access before the bus could answer.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("dmem_stall_sequencer: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef DMEM_TIMEOUT_EN
   logic to_tc;

   // Counter is held clear outside BUS, so it starts from zero on BUS entry.
   bus_timeout_counter #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != MSEQ_BUS),
      .enable ((state == MSEQ_BUS) && !dbus_ack),
      .tc     (to_tc)
   );

   // Ack takes priority when both land in the same cycle.
   assign timeout = (state == MSEQ_BUS) && !dbus_ack && to_tc;
`else
   assign timeout = 1'b0;
`endif

   // Freeze while an access is being launched or is on the bus, or when
   // another multicycle unit asks for it. DONE contributes nothing itself.
   assign stall_pipl = ((state == MSEQ_IDLE) && mem_req)
                     || (state == MSEQ_BUS)
                     || ext_stall;

   assign dbg_state = state;

   // Access sequencer: state and all bus/response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= MSEQ_IDLE;
         mem_rdata  <= '0;
         mem_done   <= 1'b0;
         bus_err    <= 1'b0;
         dbus_cyc   <= 1'b0;
         dbus_stb   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_wdata <= '0;
         dbus_sel   <= '0;
      end else begin
         case (state)
            MSEQ_IDLE: begin
               if (mem_req) begin
                  dbus_we    <= mem_we;
                  dbus_addr  <= mem_addr;
                  dbus_wdata <= mem_wdata;
                  dbus_sel   <= mem_sel;
                  dbus_cyc   <= 1'b1;
                  dbus_stb   <= 1'b1;
                  state      <= MSEQ_BUS;
               end
            end
            MSEQ_BUS: begin
               if (dbus_ack) begin
                  mem_rdata <= dbus_we ? '0 : dbus_rdata;
                  dbus_cyc  <= 1'b0;
                  dbus_stb  <= 1'b0;
                  mem_done  <= 1'b1;
                  bus_err   <= 1'b0;
                  state     <= MSEQ_DONE;
               end else if (timeout) begin
                  mem_rdata <= '0;
                  dbus_cyc  <= 1'b0;
                  dbus_stb  <= 1'b0;
                  mem_done  <= 1'b1;
                  bus_err   <= 1'b1;
                  state     <= MSEQ_DONE;
               end
            end
            MSEQ_DONE: begin
               // mem_req here still belongs to the finished instruction.
               if (!ext_stall) begin
                  mem_done <= 1'b0;
                  bus_err  <= 1'b0;
                  state    <= MSEQ_IDLE;
               end
            end
            default: begin
               state <= MSEQ_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_stall_sequencer.sv
// Self-checking bench for dmem_stall_sequencer. Builds with or without
// DMEM_TIMEOUT_EN; timeout scenarios are only exercised when it is defined.
module tb_dmem_stall_sequencer;
   import core_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;
`ifdef DMEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic [SW-1:0] mem_sel = '0;
   logic          ext_stall = 1'b0;
   logic          stall_pipl;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;
   logic          bus_err;
   logic          dbus_cyc;
   logic          dbus_stb;
   logic          dbus_we;
   logic [AW-1:0] dbus_addr;
   logic [DW-1:0] dbus_wdata;
   logic [SW-1:0] dbus_sel;
   logic [DW-1:0] dbus_rdata = '0;
   logic          dbus_ack = 1'b0;
   mseq_state_t   dbg_state;

   dmem_stall_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
      .ext_stall(ext_stall), .stall_pipl(stall_pipl), .mem_rdata(mem_rdata),
      .mem_done(mem_done), .bus_err(bus_err), .dbus_cyc(dbus_cyc),
      .dbus_stb(dbus_stb), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_sel(dbus_sel), .dbus_rdata(dbus_rdata),
      .dbus_ack(dbus_ack), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail = 0;
   int cyc_rises = 0;
   int exp_rises = 0;
   logic [DW:0] exp_q[$];   // {bus_err, mem_rdata} per access

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Reference: number of BUS cycles and whether the access ends in error.
   // The access ends on the acknowledging cycle (ws+1) unless the timeout
   // (when built in) expires first at cycle TO; a tie goes to the ack.
   function automatic int bus_len(input int ws, input bit no_ack, output bit err);
      if (TO_EN && (no_ack || (ws + 1 > TO))) begin
         err = 1'b1;
         return TO;
      end
      err = 1'b0;
      return ws + 1;
   endfunction

   // ---------------- bus cycle counter ----------------
   logic cyc_q = 1'b0;
   always @(negedge clk) begin
      if (dbus_cyc && !cyc_q) cyc_rises++;
      cyc_q = dbus_cyc;
   end

   // ---------------- response monitor ----------------
   logic done_q = 1'b0;
   always @(negedge clk) begin
      logic [DW:0] exp;
      if (mem_done && !done_q) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done at %0t: got done, expected none", $time);
         end else begin
            exp = exp_q.pop_front();
            check("done_resp", 64'({bus_err, mem_rdata}), 64'(exp));
         end
      end
      done_q = mem_done;
   end

   // ---------------- driver tasks ----------------
   // One complete access: issue cycle, BUS cycles, DONE cycles (hold extra
   // DONE cycles are requested by ext_stall).
   task automatic access(input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] sel,
                         input int ws, input bit no_ack,
                         input logic [DW-1:0] rdata, input int hold);
      bit            err;
      int            blen;
      logic [DW-1:0] exp_rd;
      blen   = bus_len(ws, no_ack, err);
      exp_rd = (we || err) ? '0 : rdata;
      exp_q.push_back({err, exp_rd});
      exp_rises++;
      // issue cycle (FSM idle); stray ack and ext_stall must not matter
      @(negedge clk);
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_sel = sel;
      ext_stall = rbit(); dbus_ack = rbit(); dbus_rdata = $urandom;
      #1;
      check("stall_issue", 64'(stall_pipl), 64'(1));
      check("cyc_issue", 64'(dbus_cyc), 64'(0));
      // bus cycles; MEM-side fields change to prove they were latched
      for (int b = 1; b <= blen; b++) begin
         @(negedge clk);
         mem_addr = $urandom; mem_wdata = $urandom; mem_we = rbit();
         mem_sel = SW'($urandom); ext_stall = rbit();
         dbus_ack = !no_ack && (b == ws + 1);
         dbus_rdata = (b == ws + 1) ? rdata : $urandom;
         #1;
         check("bus_cyc", 64'({dbus_cyc, dbus_stb}), 64'(2'b11));
         check("bus_stall", 64'(stall_pipl), 64'(1));
         check("bus_done", 64'(mem_done), 64'(0));
         if (b == 1) begin
            check("bus_we", 64'(dbus_we), 64'(we));
            check("bus_addr", 64'(dbus_addr), 64'(addr));
            check("bus_wdata", 64'(dbus_wdata), 64'(wdata));
            check("bus_sel", 64'(dbus_sel), 64'(sel));
         end
      end
      // done cycles
      for (int d = 0; d <= hold; d++) begin
         @(negedge clk);
         ext_stall = (d < hold); dbus_ack = rbit(); dbus_rdata = $urandom;
         #1;
         check("done_flag", 64'(mem_done), 64'(1));
         check("done_state", 64'(dbg_state), 64'(MSEQ_DONE));
         check("done_rdata", 64'(mem_rdata), 64'(exp_rd));
         check("done_err", 64'(bus_err), 64'(err));
         check("done_stall", 64'(stall_pipl), 64'(d < hold));
         check("done_cyc", 64'(dbus_cyc), 64'(0));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mem_req = 1'b0; ext_stall = 1'b0; dbus_ack = rbit(); dbus_rdata = $urandom;
         #1;
         check("idle_stall", 64'(stall_pipl), 64'(0));
         check("idle_cyc", 64'(dbus_cyc), 64'(0));
         check("idle_state", 64'(dbg_state), 64'(MSEQ_IDLE));
         check("idle_done", 64'(mem_done), 64'(0));
      end
   endtask

   task automatic reset_during_bus();
      exp_rises++;
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500; ext_stall = 1'b0; dbus_ack = 1'b0;
      @(negedge clk);
      #1;
      check("rst_bus_cyc", 64'(dbus_cyc), 64'(1));
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("rst_cyc", 64'(dbus_cyc), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(MSEQ_IDLE));
      check("rst_stall_req", 64'(stall_pipl), 64'(1));
      check("rst_err", 64'({bus_err, mem_done}), 64'(0));
      check("rst_rdata", 64'(mem_rdata), 64'(0));
      @(negedge clk);
      reset = 1'b0; mem_req = 1'b0;
      #1;
      check("rst_stall_noreq", 64'(stall_pipl), 64'(0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int r0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outs", 64'({stall_pipl, mem_done, bus_err, dbus_cyc, dbus_stb, dbus_we}), 64'(0));
      check("reset_regs", 64'({dbus_addr, dbus_sel}) | 64'(dbus_wdata) | 64'(mem_rdata), 64'(0));
      check("reset_state", 64'(dbg_state), 64'(MSEQ_IDLE));
      @(negedge clk);
      reset = 1'b0;

      // load, three wait states
      access(1'b0, 32'h100, 32'h0, 4'hF, 3, 1'b0, 32'hDEADBEEF, 0);
      idle(1);
      // store, immediate ack
      access(1'b1, 32'h204, 32'hCAFEF00D, 4'b0011, 0, 1'b0, 32'h11112222, 0);
      idle(1);
      // external stall held 4 cycles from DONE; one bus cycle only
      r0 = cyc_rises;
      access(1'b0, 32'h300, 32'h0, 4'hF, 1, 1'b0, 32'h12345678, 4);
      idle(1);
      check("ext_one_cycle", 64'(cyc_rises - r0), 64'(1));
      // back-to-back loads with mem_req held
      r0 = cyc_rises;
      access(1'b0, 32'h340, 32'h0, 4'hF, 0, 1'b0, 32'hA0A0A0A0, 0);
      access(1'b0, 32'h344, 32'h0, 4'hF, 2, 1'b0, 32'h0B0B0B0B, 0);
      idle(1);
      check("b2b_two_cycles", 64'(cyc_rises - r0), 64'(2));
      // reset in the middle of a bus cycle
      reset_during_bus();
      idle(1);
`ifdef DMEM_TIMEOUT_EN
      access(1'b0, 32'h400, 32'h0, 4'hF, 0, 1'b1, 32'h55555555, 0);   // never acked
      idle(1);
      access(1'b0, 32'h404, 32'h0, 4'hF, TO - 1, 1'b0, 32'hA5A5A5A5, 0); // ack on last cycle
      idle(1);
      access(1'b0, 32'h408, 32'h0, 4'hF, TO, 1'b0, 32'h5A5A5A5A, 2);   // ack too late
      idle(1);
`endif
      // randomized accesses
      for (int i = 0; i < 40; i++) begin
         int gap;
         access(rbit(), $urandom, $urandom, SW'($urandom),
                TO_EN ? int'($urandom_range(0, TO + 2)) : int'($urandom_range(0, 5)),
                TO_EN && ($urandom_range(0, 9) == 0), $urandom,
                int'($urandom_range(0, 2)));
         gap = int'($urandom_range(0, 2));
         if (gap > 0) idle(gap);
      end
      idle(2);
      check("cyc_pulses", 64'(cyc_rises), 64'(exp_rises));
      check("exp_q_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
